// File: rtl/decode_writeback.sv
// SEQ Y86-64 decode/write-back: src/dst selection and a 15-entry register file. Optional REGFILE_BYPASS_EN forwards pending writes to the read ports.
// Latency: reads are combinational; a write commits on the rising edge and is visible the following cycle (same cycle with bypass).
// Backpressure: wb_en=0 stalls all commits while reads and dst selects stay live; rst overrides wb_en.
module decode_writeback #(
    parameter int                DATA_W   = 64,
    parameter logic [DATA_W-1:0] RSP_INIT = 64'h0000_0000_0000_0200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        icode,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic              cnd,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valM,
    input  logic              wb_en,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    output logic [3:0]        dstE,
    output logic [3:0]        dstM
);

    localparam logic [3:0] REG_NONE = 4'hF;
    localparam logic [3:0] REG_RSP  = 4'h4;

    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    logic [DATA_W-1:0] regs_q [15];
    logic [DATA_W-1:0] regs_d [15];
    logic [3:0]        src_a;
    logic [3:0]        src_b;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    always_comb begin
        src_a = REG_NONE;
        src_b = REG_NONE;
        dstE  = REG_NONE;
        dstM  = REG_NONE;

        case (icode)
            I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: src_a = rA;
            I_RET, I_POPQ:                      src_a = REG_RSP;
            default:                            src_a = REG_NONE;
        endcase

        case (icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ:          src_b = rB;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:     src_b = REG_RSP;
            default:                            src_b = REG_NONE;
        endcase

        // rrmovq is cmov with an always-true condition, so cnd gates both
        case (icode)
            I_RRMOVQ:                           dstE = cnd ? rB : REG_NONE;
            I_IRMOVQ, I_OPQ:                    dstE = rB;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:     dstE = REG_RSP;
            default:                            dstE = REG_NONE;
        endcase

        case (icode)
            I_MRMOVQ, I_POPQ:                   dstM = rA;
            default:                            dstM = REG_NONE;
        endcase
    end

    // M port is applied last so popq %rsp keeps the loaded value
    always_comb begin
        regs_d = regs_q;
        if (wb_en) begin
            if (dstE != REG_NONE) regs_d[dstE] = valE;
            if (dstM != REG_NONE) regs_d[dstM] = valM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 15; i++) begin
                regs_q[i] <= (i == 4) ? RSP_INIT : '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd_a = (src_a == REG_NONE) ? '0 : regs_q[src_a];
    assign rd_b = (src_b == REG_NONE) ? '0 : regs_q[src_b];

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        valA = rd_a;
        valB = rd_b;
        if (wb_en && src_a != REG_NONE) begin
            if (src_a == dstM)      valA = valM;
            else if (src_a == dstE) valA = valE;
        end
        if (wb_en && src_b != REG_NONE) begin
            if (src_b == dstM)      valB = valM;
            else if (src_b == dstE) valB = valE;
        end
    end
`else
    assign valA = rd_a;
    assign valB = rd_b;
`endif

endmodule

// File: tb/tb_decode_writeback.sv
// Directed table-driven bench for decode_writeback; each row checks pre-edge outputs, then commits on the edge.
module tb_decode_writeback;

    localparam int DATA_W = 64;
    localparam logic [63:0] RSP_INIT = 64'h0000_0000_0000_0200;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        icode, rA, rB;
    logic              cnd, wb_en;
    logic [DATA_W-1:0] valE, valM, valA, valB;
    logic [3:0]        dstE, dstM;

    int n_tests = 0;
    int n_fail  = 0;

    decode_writeback #(.DATA_W(DATA_W), .RSP_INIT(RSP_INIT)) dut (
        .clk(clk), .rst(rst), .icode(icode), .rA(rA), .rB(rB), .cnd(cnd),
        .valE(valE), .valM(valM), .wb_en(wb_en),
        .valA(valA), .valB(valB), .dstE(dstE), .dstM(dstM)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  icode;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic        cnd;
        logic        wb;
        logic [63:0] val_e;
        logic [63:0] val_m;
        logic [63:0] va;
        logic [63:0] vb;
        logic [63:0] bva;
        logic [63:0] bvb;
        logic [3:0]  de;
        logic [3:0]  dm;
        logic        chk;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    task automatic check(input string name, input int row, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst   = v.rst;
        icode = v.icode;
        rA    = v.ra;
        rB    = v.rb;
        cnd   = v.cnd;
        wb_en = v.wb;
        valE  = v.val_e;
        valM  = v.val_m;
    endtask

    initial begin
        //          rst icode ra    rb    cnd wb  valE        valM        valA        valB        byp valA    byp valB    dstE  dstM  chk
        vecs[0]  = '{1, 4'h0, 4'hF, 4'hF, 0, 0, 64'h0,      64'h0,      64'h0,      64'h0,      64'h0,      64'h0,      4'hF, 4'hF, 0};
        vecs[1]  = '{0, 4'hA, 4'h3, 4'hF, 0, 0, 64'h0,      64'h0,      64'h0,      64'h200,    64'h0,      64'h200,    4'h4, 4'hF, 1};
        vecs[2]  = '{0, 4'h3, 4'hF, 4'h2, 0, 1, 64'h1234,   64'h0,      64'h0,      64'h0,      64'h0,      64'h0,      4'h2, 4'hF, 1};
        vecs[3]  = '{0, 4'h2, 4'h2, 4'h5, 0, 1, 64'h7,      64'h0,      64'h1234,   64'h0,      64'h1234,   64'h0,      4'hF, 4'hF, 1};
        vecs[4]  = '{0, 4'h2, 4'h5, 4'h5, 1, 1, 64'h7,      64'h0,      64'h0,      64'h0,      64'h7,      64'h0,      4'h5, 4'hF, 1};
        vecs[5]  = '{0, 4'h6, 4'h5, 4'h3, 0, 0, 64'hAA,     64'h0,      64'h7,      64'h0,      64'h7,      64'h0,      4'h3, 4'hF, 1};
        vecs[6]  = '{0, 4'hB, 4'h4, 4'hF, 0, 1, 64'h208,    64'hBEEF,   64'h200,    64'h200,    64'hBEEF,   64'hBEEF,   4'h4, 4'h4, 1};
        vecs[7]  = '{0, 4'hB, 4'h1, 4'hF, 0, 1, 64'h208,    64'h55,     64'hBEEF,   64'hBEEF,   64'h208,    64'h208,    4'h4, 4'h1, 1};
        vecs[8]  = '{0, 4'h6, 4'h1, 4'h3, 0, 0, 64'h0,      64'h0,      64'h55,     64'h0,      64'h55,     64'h0,      4'h3, 4'hF, 1};
        vecs[9]  = '{0, 4'h5, 4'h6, 4'h4, 0, 1, 64'h0,      64'h77,     64'h0,      64'h208,    64'h0,      64'h208,    4'hF, 4'h6, 1};
        vecs[10] = '{0, 4'hC, 4'h6, 4'h6, 1, 1, 64'h1,      64'h2,      64'h0,      64'h0,      64'h0,      64'h0,      4'hF, 4'hF, 1};
        vecs[11] = '{0, 4'h2, 4'h6, 4'h0, 1, 1, 64'h99,     64'h0,      64'h77,     64'h0,      64'h77,     64'h0,      4'h0, 4'hF, 1};
        vecs[12] = '{0, 4'hA, 4'h0, 4'hF, 0, 0, 64'h0,      64'h0,      64'h99,     64'h208,    64'h99,     64'h208,    4'h4, 4'hF, 1};
        vecs[13] = '{1, 4'h6, 4'h2, 4'h3, 0, 1, 64'h33,     64'h0,      64'h1234,   64'h0,      64'h1234,   64'h33,     4'h3, 4'hF, 1};
        vecs[14] = '{0, 4'h6, 4'h2, 4'h4, 0, 0, 64'h0,      64'h0,      64'h0,      64'h200,    64'h0,      64'h200,    4'h4, 4'hF, 1};
        vecs[15] = '{0, 4'h9, 4'hF, 4'hF, 0, 0, 64'h0,      64'h0,      64'h200,    64'h200,    64'h200,    64'h200,    4'h4, 4'hF, 1};
        vecs[16] = '{0, 4'h8, 4'hF, 4'hF, 0, 0, 64'h0,      64'h0,      64'h0,      64'h200,    64'h0,      64'h200,    4'h4, 4'hF, 1};
        vecs[17] = '{0, 4'h6, 4'h5, 4'h6, 0, 0, 64'h0,      64'h0,      64'h0,      64'h0,      64'h0,      64'h0,      4'h6, 4'hF, 1};
        vecs[18] = '{0, 4'h5, 4'h7, 4'h1, 0, 0, 64'h0,      64'h0,      64'h0,      64'h0,      64'h0,      64'h0,      4'hF, 4'h7, 1};

        drive(vecs[0]);
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            #1;
            if (vecs[i].chk) begin
                check("valA", i, valA, BYP ? vecs[i].bva : vecs[i].va);
                check("valB", i, valB, BYP ? vecs[i].bvb : vecs[i].vb);
                check("dstE", i, {60'h0, dstE}, {60'h0, vecs[i].de});
                check("dstM", i, {60'h0, dstM}, {60'h0, vecs[i].dm});
            end
            @(posedge clk);
            #1;
        end

        // write to reg 3 while reading it: same-cycle only with bypass, next cycle otherwise
        rst = 1'b0; icode = 4'h6; rA = 4'h3; rB = 4'h3; cnd = 1'b0;
        valE = 64'h9; valM = 64'h0; wb_en = 1'b1;
        #1;
        check("wr_same_cycle_valA", 100, valA, BYP ? 64'h9 : 64'h0);
        check("wr_same_cycle_dstE", 100, {60'h0, dstE}, 64'h3);
        @(posedge clk);
        #1;
        wb_en = 1'b0; valE = 64'h0;
        #1;
        check("wr_next_cycle_valA", 101, valA, 64'h9);
        check("wr_next_cycle_valB", 101, valB, 64'h9);

        // reset held over several cycles keeps %rsp at its initial value
        rst = 1'b1; wb_en = 1'b1; icode = 4'hA; rA = 4'h3; valE = 64'hDEAD;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; wb_en = 1'b0;
        #1;
        check("rst_hold_valA", 102, valA, 64'h0);
        check("rst_hold_valB", 102, valB, RSP_INIT);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_writeback.md
Name: decode_writeback

Overview:
- Register-file and write-back block for the SEQ Y86-64 datapath: the other end of the execute stage.
- Decode side: selects srcA/srcB from icode/rA/rB and drives valA/valB, which execute consumes as ALU operands.
- Write-back side: selects dstE/dstM, takes valE and cnd back from execute and valM from memory, and commits them to the 15-entry register file on the clock edge.

Parameters:
- DATA_W, 64, register and data width.
- RSP_INIT, 64'h0000_0000_0000_0200, reset value of %rsp (register 4).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- icode  input  4  instruction code of the current instruction.
- rA  input  4  register specifier A; 4'hF means none.
- rB  input  4  register specifier B; 4'hF means none.
- cnd  input  1  condition result from execute; gates cmovXX write-back.
- valE  input  DATA_W  ALU result from execute.
- valM  input  DATA_W  memory read data.
- wb_en  input  1  commit strobe; writes occur only when 1, so the sequencer can stall or halt.
- valA  output  DATA_W  read data for srcA.
- valB  output  DATA_W  read data for srcB.
- dstE  output  4  selected E destination; exposed for debug and verification.
- dstM  output  4  selected M destination.

Behaviour:
- Storage: 15 x DATA_W registers, ids 0..14. Id 4'hF means "none".
- Reset (synchronous, rst=1 at posedge):
  - All registers clear to 0, except register 4 (%rsp), which loads RSP_INIT.
  - rst overrides wb_en in the same cycle.
- srcA selection (combinational):
  - icode 2, 4, 6, A -> rA.
  - icode 9, B -> 4.
  - otherwise -> F.
- srcB selection:
  - icode 4, 5, 6 -> rB.
  - icode 8, 9, A, B -> 4.
  - otherwise -> F.
- dstE selection:
  - icode 2 -> rB if cnd=1, else F. Covers rrmovq (ifun 0, cnd always 1) and cmovXX.
  - icode 3, 6 -> rB.
  - icode 8, 9, A, B -> 4.
  - otherwise -> F.
- dstM selection:
  - icode 5, B -> rA.
  - otherwise -> F.
- Read ports:
  - valA = reg[srcA] and valB = reg[srcB], combinational, zero-cycle latency.
  - A source id of F returns 0.
  - Reads return the pre-edge register value; there is no write-through (see Optional Feature).
- Write ports, on posedge with wb_en=1 and rst=0:
  - If dstE != F: reg[dstE] <= valE.
  - If dstM != F: reg[dstM] <= valM.
  - If dstE == dstM != F (popq %rsp): the M port wins and the register gets valM.
  - Both ports may write different registers in the same cycle.
- wb_en=0: no register changes. Read ports and dst outputs stay live.
- Icode outside 0..B: all selects are F; no reads, no writes.
- Latency: a write is visible on valA/valB in the cycle after the committing edge.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: read ports forward in the same cycle.
  - If wb_en=1, srcX != F and srcX matches a pending write, valX returns the incoming data instead of the stored value.
  - dstM takes priority over dstE, consistent with the write priority.
  - Used when this block is reused in the pipelined core.
- Undefined: pure register reads as specified above. No bypass logic is synthesised.

Test Plan:
- Reset: pulse rst, then icode=A (pushq), rA=3 -> valA=0 (reg 3), valB=RSP_INIT (reg 4).
- irmovq write: icode=3, rB=2, valE=64'h1234, wb_en=1, one edge; then icode=2, rA=2 -> valA=64'h1234.
- cmov gating:
  - icode=2, rB=5, cnd=0, valE=7 -> dstE=F; reg 5 stays 0 after the edge.
  - Same with cnd=1 -> reg 5 = 7.
- popq %rsp priority: icode=B, rA=4, valE=RSP_INIT+8, valM=64'hBEEF, commit -> reg 4 = 64'hBEEF.
- Dual write: icode=B, rA=1, valE=0x208, valM=0x55, commit -> reg 4 = 0x208, reg 1 = 0x55, in the same edge.
- Stall and mid-operation reset:
  - wb_en=0 with icode=6, rB=3 -> reg 3 unchanged.
  - rst=1 together with wb_en=1 on a write -> registers return to reset values.
  - With REGFILE_BYPASS_EN defined, a write of valE=9 to reg 3 with srcA=3 gives valA=9 in the same cycle.
